// File: rtl/mdu_ctrl.sv
// ============================================================================
//  Module   : mdu_ctrl
//  Brief    : Multi-cycle multiply/divide unit with HI/LO registers for the
//             E stage of the P6 pipelined core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] t_hi, t_lo, t_hi_next, t_lo_next;
  logic [31:0] hi_next, lo_next;

  // Arithmetic datapath, evaluated on the current operands every cycle
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag, mag_q, mag_r;
  logic [31:0] sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic [3:0]  res_load;

  always_comb begin
    prod_s = $signed({{32{SA[31]}}, SA}) * $signed({{32{SB[31]}}, SB});
    prod_u = {32'd0, SA} * {32'd0, SB};
  end

  // Signed division is done on magnitudes so results never rely on how a
  // tool treats $signed division corner cases.
  always_comb begin
    a_neg    = SA[31];
    b_neg    = SB[31];
    a_mag    = a_neg ? (32'd0 - SA) : SA;
    b_mag    = b_neg ? (32'd0 - SB) : SB;
    div_zero = (SB == 32'd0);
    div_ovf  = (SA == 32'h8000_0000) && (SB == 32'hFFFF_FFFF);
    mag_q    = 32'd0;
    mag_r    = 32'd0;
    uq       = 32'd0;
    ur       = 32'd0;
    if (!div_zero) begin
      mag_q = a_mag / b_mag;
      mag_r = a_mag % b_mag;
      uq    = SA / SB;
      ur    = SA % SB;
    end
    sq = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
    sr = a_neg ? (32'd0 - mag_r) : mag_r;
  end

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    res_load = MULT_LOAD;
    case (MDUOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_load = DIV_LOAD;
        if (div_zero) begin
          res_hi = SA;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        res_load = DIV_LOAD;
        if (div_zero) begin
          res_hi = SA;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Sequencer next-state
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    t_hi_next  = t_hi;
    t_lo_next  = t_lo;
    hi_next    = HI;
    lo_next    = LO;
    case (state)
      IDLE: begin
        if (Start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              t_hi_next  = res_hi;
              t_lo_next  = res_lo;
              cnt_next   = res_load;
              state_next = RUN;
            end
            OP_MTHI: hi_next = SA;
            OP_MTLO: lo_next = SA;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Commands arriving while busy are dropped on purpose.
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          hi_next    = t_hi;
          lo_next    = t_lo;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      t_hi  <= 32'd0;
      t_lo  <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      t_hi  <= t_hi_next;
      t_lo  <= t_lo_next;
      HI    <= hi_next;
      LO    <= lo_next;
    end
  end

  assign Busy = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
//  Module   : tb_mdu_ctrl
//  Brief    : Directed self-checking bench for mdu_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] SA, SB;
  logic        Busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDUOp (MDUOp),
    .SA    (SA),
    .SB    (SB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // One-cycle command: drive at a falling edge, return at the next falling edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; SA = a; SB = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
  endtask

  // Busy must stay high n cycles with HI/LO frozen, then drop with the result
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] old_hi,
                        input logic [31:0] old_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int i = 0; i < n; i++) begin
      total++;
      if (Busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
        bad++;
        $display("FAIL %s busy cycle %0d: Busy=%b HI=%h LO=%h want Busy=1 HI=%h LO=%h",
                 name, i, Busy, HI, LO, old_hi, old_lo);
      end
      @(negedge clk);
    end
    total++;
    if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      bad++;
      $display("FAIL %s result: Busy=%b HI=%h LO=%h want Busy=0 HI=%h LO=%h",
               name, Busy, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; SA = 32'd0; SB = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        bad++;
        $display("FAIL reset idle %0d: Busy=%b HI=%h LO=%h want 0/0/0", i, Busy, HI, LO);
      end
    end
    issue(4'b0111, 32'h1111_1111, 32'h2222_2222);
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL undefined op: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_mult;
    run_op("mult", 4'b0001, 32'hFFFF_FFFF, 32'd2, 5, 32'd0, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'b0010, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div;
    run_op("div", 4'b0011, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 4'b0100, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd1, 32'd3);
  endtask

  task automatic test_div_corner;
    run_op("div0", 4'b0011, 32'h1234_5678, 32'd0, 10, 32'd1, 32'd3,
           32'h1234_5678, 32'hFFFF_FFFF);
    run_op("divovf", 4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h1234_5678,
           32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu0", 4'b0100, 32'h8765_4321, 32'd0, 10, 32'd0, 32'h8000_0000,
           32'h8765_4321, 32'hFFFF_FFFF);
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'b0101; SA = 32'hAAAA_0000;
    @(negedge clk);
    total++;
    if (Busy !== 1'b0 || HI !== 32'hAAAA_0000 || LO !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL mthi: Busy=%b HI=%h LO=%h want 0/aaaa0000/ffffffff", Busy, HI, LO);
    end
    MDUOp = 4'b0110; SA = 32'h0000_5555;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    total++;
    if (Busy !== 1'b0 || HI !== 32'hAAAA_0000 || LO !== 32'h0000_5555) begin
      bad++;
      $display("FAIL mtlo: Busy=%b HI=%h LO=%h want 0/aaaa0000/00005555", Busy, HI, LO);
    end
  endtask

  task automatic test_busy_ignore;
    issue(4'b0001, 32'd3, 32'd4);
    Start = 1'b1; MDUOp = 4'b0101; SA = 32'h0000_DEAD; SB = 32'h7777_7777;
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'b0011; SA = 32'hFFFF_0000; SB = 32'd9;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0; SA = 32'h0101_0101; SB = 32'h0;
    total++;
    if (Busy !== 1'b1 || HI !== 32'hAAAA_0000 || LO !== 32'h0000_5555) begin
      bad++;
      $display("FAIL ignore mid-run: Busy=%b HI=%h LO=%h want 1/aaaa0000/00005555",
               Busy, HI, LO);
    end
    repeat (3) @(negedge clk);
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
      bad++;
      $display("FAIL ignore result: Busy=%b HI=%h LO=%h want 0/0/c", Busy, HI, LO);
    end
    @(negedge clk);
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
      bad++;
      $display("FAIL ignore no-restart: Busy=%b HI=%h LO=%h want 0/0/c", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_midop;
    issue(4'b0100, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL midop busy: Busy=%b want 1", Busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL midop reset: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        total++;
        bad++;
        $display("FAIL midop late commit %0d: Busy=%b HI=%h LO=%h want 0/0/0",
                 i, Busy, HI, LO);
      end
    end
    total++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      bad++;
      $display("FAIL midop final: HI=%h LO=%h want 0/0", HI, LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
